uart_transmitter: RTL

- Serialises one byte per handshake onto the UART line; the transmit-side counterpart of the UART receiver.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. The baud rate is set by a clock-divide parameter.
- Sits between the byte-producing logic (FIFO, command engine, or loopback from the receiver) and the FPGA TX pin.

---
 rtl/uart_transmitter_if.sv | 18 +
 rtl/uart_transmitter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_transmitter_if
// Purpose  : Byte handshake and line-status bundle for the UART transmitter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output data_in, data_valid, input ready, tx, busy, done);
  modport slave  (input data_in, data_valid, output ready, tx, busy, done);
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_transmitter
// Purpose  : Serialises one byte per handshake: start, 8 data LSB first,
//            optional parity, 1 or 2 stop bits. tx is always a flop output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_transmitter_if.slave  bus
);

  localparam int                 c_CNT_W     = $clog2(CLOCKS_PER_PULSE);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [2:0]         c_STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] c_TX_IDLE   = 3'd0;
  localparam logic [2:0] c_TX_START  = 3'd1;
  localparam logic [2:0] c_TX_DATA   = 3'd2;
  localparam logic [2:0] c_TX_PARITY = 3'd3;
  localparam logic [2:0] c_TX_STOP   = 3'd4;

  generate
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        CLOCKS_PER_PULSE < 2) begin : g_param_check
      $error("uart_transmitter: illegal PARITY, STOP_BITS or CLOCKS_PER_PULSE");
    end
  endgenerate

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic w_accept;
  logic w_period_end;

  assign w_accept     = bus.data_valid & r_ready;
  assign w_period_end = (r_clk_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_TX_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Counter free-runs through every active bit period and rests in idle.
      r_clk_cnt <= (r_state == c_TX_IDLE || w_period_end) ? '0 : r_clk_cnt + 1'b1;
      case (r_state)
        c_TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shift   <= bus.data_in;
            r_parity  <= (PARITY == 2) ? ~^bus.data_in : ^bus.data_in;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= c_TX_START;
          end
        end
        c_TX_START: begin
          if (w_period_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= '0;
            r_state   <= c_TX_DATA;
          end
        end
        c_TX_DATA: begin
          if (w_period_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_parity;
                r_state <= c_TX_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= c_TX_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        c_TX_PARITY: begin
          if (w_period_end) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= c_TX_STOP;
          end
        end
        c_TX_STOP: begin
          // r_bit_cnt is reused here to count stop periods.
          if (w_period_end) begin
            if (r_bit_cnt == c_STOP_LAST) begin
              r_state <= c_TX_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_state   <= c_TX_IDLE;
          r_tx      <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.tx    = r_tx;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule
`default_nettype wire
